shift_right_seq: RTL

Multi-cycle right-shift unit for the lab CPU datapath: the right-direction counterpart of the fixed left-shift-by-two used for branch offsets. It executes SRL/SRA by a variable 5-bit shift amount, shifting up to 4 bits per cycle under a start/done handshake. It sits beside the ALU, is launched by the controller for variable shifts, and stalls the pipeline while `busy_o` is high.

---
 rtl/shift_right_seq.sv | 82 ++++++++
 1 files changed

// File: rtl/shift_right_seq.sv
// Multi-cycle SRL/SRA unit: shifts by up to 4 bits per cycle under a start/done handshake.
// The controller stalls the pipeline while busy_o is high.
module shift_right_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [4:0]       shamt_i,
  input  logic             arith_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start_i is sampled only in IDLE; done_o is a one-cycle pulse
  // with data_o valid in that cycle; data_o holds until the next completion.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [4:0]       r_rem;
  logic             r_fill;
  logic [WIDTH-1:0] r_data;

  logic             w_big;
  logic [WIDTH-1:0] w_step;
  logic [4:0]       w_rem_next;

  // Take a 4-bit stride while at least 4 remain, then finish one bit at a time.
  assign w_big      = (r_rem >= 5'd4);
  assign w_step     = w_big ? {{4{r_fill}}, r_work[WIDTH-1:4]} : {r_fill, r_work[WIDTH-1:1]};
  assign w_rem_next = r_rem - (w_big ? 5'd4 : 5'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_rem   <= '0;
      r_fill  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_work <= data_i;
            r_rem  <= shamt_i;
            r_fill <= arith_i & data_i[WIDTH-1];
            if (shamt_i == 5'd0) begin
              r_data  <= data_i;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_step;
          r_rem  <= w_rem_next;
          if (w_rem_next == 5'd0) begin
            r_data  <= w_step;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign data_o      = r_data;
  assign dbg_state_o = r_state;

endmodule
